// File: rtl/dram_loader_pkg.sv
// Shared definitions for the data-RAM bulk loader: FSM state encoding and transfer modes.
package dram_loader_pkg;

   typedef enum logic [3:0] {
      IDLE,
      LD_LO,
      LD_HI,
      LD_WR,
      RD_REQ,
      RD_WAIT,
      TX_LO,
      TX_HI,
      DONE
   } state_t;

   localparam logic MODE_LOAD = 1'b0;
   localparam logic MODE_DUMP = 1'b1;

endpackage

// File: rtl/dram_loader_addr_ctr.sv
// Address / remaining-word counter for the loader; flags when the current word is the last one.
module loader_addr_ctr #(
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] word_count,
   input  logic              step,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   logic [ADDR_W-1:0] rem;

   always_ff @(posedge clk) begin
      if (rst) begin
         addr <= '0;
         rem  <= '0;
      end else if (load) begin
         addr <= base_addr;
         rem  <= word_count;
      end else if (step) begin
         // Address wraps naturally at 2**ADDR_W; rem saturates at zero.
         addr <= addr + ADDR_W'(1);
         if (rem != '0) rem <= rem - ADDR_W'(1);
      end
   end

   assign last = (rem == ADDR_W'(1));

endmodule

// File: rtl/dram_loader.sv
// Bulk-transfer engine on the data-RAM port: packs a byte stream into RAM words (LOAD)
// or streams RAM words out as byte pairs (DUMP), little-endian.
module dram_loader
   import dram_loader_pkg::*;
#(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16,
   parameter int BYTE_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] word_count,
   input  logic [BYTE_W-1:0] in_byte,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [BYTE_W-1:0] out_byte,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              ram_write_en,
   output logic              ram_read_en,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              done
);

   state_t            state;
   logic [DATA_W-1:0] word;
   logic [ADDR_W-1:0] addr;
   logic              last;
   logic              ctr_load;
   logic              ctr_step;

   assign ctr_load = (state == IDLE) && start;
   assign ctr_step = (state == LD_WR) || ((state == TX_HI) && out_ready);

   loader_addr_ctr #(.ADDR_W(ADDR_W)) u_ctr (
      .clk        (clk),
      .rst        (rst),
      .load       (ctr_load),
      .base_addr  (base_addr),
      .word_count (word_count),
      .step       (ctr_step),
      .addr       (addr),
      .last       (last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         word  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (word_count == '0)       state <= DONE;
                  else if (mode == MODE_DUMP) state <= RD_REQ;
                  else                        state <= LD_LO;
               end
            end
            LD_LO: begin
               if (in_valid) begin
                  word[BYTE_W-1:0] <= in_byte;
                  state            <= LD_HI;
               end
            end
            LD_HI: begin
               if (in_valid) begin
                  word[DATA_W-1:BYTE_W] <= in_byte;
                  state                 <= LD_WR;
               end
            end
            LD_WR:   state <= last ? DONE : LD_LO;
            RD_REQ:  state <= RD_WAIT;
            RD_WAIT: begin
               // RAM returns data one cycle after the read strobe.
               word  <= ram_rdata;
               state <= TX_LO;
            end
            TX_LO: begin
               if (out_ready) state <= TX_HI;
            end
            TX_HI: begin
               if (out_ready) state <= last ? DONE : RD_REQ;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Moore output decode from the registered state and word buffer.
   assign in_ready     = (state == LD_LO) || (state == LD_HI);
   assign out_valid    = (state == TX_LO) || (state == TX_HI);
   assign out_byte     = (state == TX_LO) ? word[BYTE_W-1:0] :
                         (state == TX_HI) ? word[DATA_W-1:BYTE_W] : '0;
   assign ram_write_en = (state == LD_WR);
   assign ram_read_en  = (state == RD_REQ);
   assign ram_addr     = ((state == LD_WR) || (state == RD_REQ)) ? addr : '0;
   assign ram_wdata    = (state == LD_WR) ? word : '0;
   assign busy         = (state != IDLE);
   assign done         = (state == DONE);

endmodule
